// File: rtl/layer_seq_ctrl.sv
`timescale 1ns/1ps
// layer_seq_ctrl: sequences a host-programmed per-layer config table over N frames to the downstream controller.
// Latency: start -> ctrl_valid 1 cycle; ctrl_finish -> next ctrl_valid (or done) 1 cycle.
// Backpressure: ctrl_valid and the payload are held in ISSUE until ctrl_ready; abort drops the request at once.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   cfg_we/cfg_addr/cfg_wdata host table write (ignored while busy)
//   num_layers_i/num_frames_i run lengths, sampled on an accepted start
//   start, abort              run control pulses
//   busy, done, err           status (err is a sticky watchdog flag)
//   layer_idx, frame_cnt      current position in the run
//   ctrl_valid/ctrl_ready     request handshake to the downstream controller
//   ctrl_finish               downstream layer-complete pulse
//   *_o                       layer payload, combinational from the table entry at layer_idx
module layer_seq_ctrl #(
    parameter int MAX_LAYERS = 8,
    parameter int TIMEOUT    = 1048576
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(MAX_LAYERS)-1:0] cfg_addr,
    input  logic [25:0]                   cfg_wdata,
    input  logic [3:0]                    num_layers_i,
    input  logic [7:0]                    num_frames_i,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [2:0]                    layer_idx,
    output logic [7:0]                    frame_cnt,
    output logic                          ctrl_valid,
    input  logic                          ctrl_ready,
    input  logic                          ctrl_finish,
    output logic [7:0]                    w_num_o,
    output logic [7:0]                    h_num_o,
    output logic [7:0]                    c_num_o,
    output logic                          kernel_mode_o,
    output logic                          bit_mode_o,
    output logic                          is_diff_o,
    output logic                          is_first_o
);

    localparam int AW  = $clog2(MAX_LAYERS);
    localparam int WDW = $clog2(TIMEOUT);
    // Timeout fires when the incremented watchdog would reach TIMEOUT-1.
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 2);
    localparam logic [3:0]     LAYER_MAX = 4'(MAX_LAYERS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_ctrl_valid;
    logic            r_done;
    logic            r_err;
    logic [2:0]      r_layer_idx;
    logic [7:0]      r_frame_cnt;
    logic [3:0]      r_num_layers;
    logic [7:0]      r_num_frames;
    logic [WDW-1:0]  r_wd;
    logic [25:0]     r_table [MAX_LAYERS];

    logic [3:0]      w_layers_clamped;
    logic [AW-1:0]   w_rd_addr;
    logic [25:0]     w_entry;
    logic            w_more_layers;
    logic            w_more_frames;

    assign w_layers_clamped = (num_layers_i > LAYER_MAX) ? LAYER_MAX : num_layers_i;
    assign w_more_layers    = ({1'b0, r_layer_idx} + 4'd1) < r_num_layers;
    assign w_more_frames    = ({1'b0, r_frame_cnt} + 9'd1) < {1'b0, r_num_frames};

    // Table has no reset; host loads it before the first run.
    always_ff @(posedge clk) begin
        if (cfg_we && (r_state == S_IDLE)) begin
            r_table[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ctrl_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_layer_idx  <= 3'd0;
            r_frame_cnt  <= 8'd0;
            r_num_layers <= 4'd0;
            r_num_frames <= 8'd0;
            r_wd         <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                // Abort beats a same-cycle handshake or finish; err is left alone.
                r_state      <= S_IDLE;
                r_ctrl_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if ((num_layers_i != 4'd0) && (num_frames_i != 8'd0)) begin
                                r_num_layers <= w_layers_clamped;
                                r_num_frames <= num_frames_i;
                                r_layer_idx  <= 3'd0;
                                r_frame_cnt  <= 8'd0;
                                r_err        <= 1'b0;
                                r_ctrl_valid <= 1'b1;
                                r_state      <= S_ISSUE;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (ctrl_ready) begin
                            r_ctrl_valid <= 1'b0;
                            r_wd         <= '0;
                            r_state      <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (ctrl_finish) begin
                            if (w_more_layers) begin
                                r_layer_idx  <= r_layer_idx + 3'd1;
                                r_ctrl_valid <= 1'b1;
                                r_state      <= S_ISSUE;
                            end else if (w_more_frames) begin
                                r_layer_idx  <= 3'd0;
                                r_frame_cnt  <= r_frame_cnt + 8'd1;
                                r_ctrl_valid <= 1'b1;
                                r_state      <= S_ISSUE;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else if (r_wd >= WD_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (r_wd != '1) begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_rd_addr     = AW'(r_layer_idx);
    assign w_entry       = r_table[w_rd_addr];

    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign err           = r_err;
    assign layer_idx     = r_layer_idx;
    assign frame_cnt     = r_frame_cnt;
    assign ctrl_valid    = r_ctrl_valid;
    assign w_num_o       = w_entry[25:18];
    assign h_num_o       = w_entry[17:10];
    assign c_num_o       = w_entry[9:2];
    assign kernel_mode_o = w_entry[1];
    assign bit_mode_o    = w_entry[0];
    assign is_first_o    = (r_layer_idx == 3'd0);
    assign is_diff_o     = (r_frame_cnt != 8'd0);

endmodule

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Frame/layer scheduler that sits above the feature-map guard-generator controller. It holds a small table of per-layer configurations, written by the host. On `start` it issues the layers one at a time over a valid/ready handshake to the downstream controller and waits for each layer's finish pulse. It repeats the layer list for a programmed number of frames. It generates `is_first` for the first layer of each frame and `is_diff` for every frame after the first, and it supervises each layer with a watchdog.

## Interface
- `MAX_LAYERS`, 8, depth of the config table; `num_layers_i` must be in the range 1..`MAX_LAYERS`.
- `TIMEOUT`, 1048576, maximum number of cycles spent in WAIT before `err` is raised; minimum value 2.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: config table write strobe.
- `cfg_addr` in $clog2(MAX_LAYERS): table entry to write.
- `cfg_wdata` in 26: packed {w_num[25:18], h_num[17:10], c_num[9:2], kernel_mode[1], bit_mode[0]}.
- `num_layers_i` in 4: number of layers per frame, sampled on an accepted `start`.
- `num_frames_i` in 8: number of frames, sampled on an accepted `start`.
- `start` in 1: start a run, one-cycle pulse.
- `abort` in 1: stop a run, one-cycle pulse.
- `busy` out 1: high while the state is not IDLE.
- `done` out 1: one-cycle pulse when a run completes normally.
- `err` out 1: sticky watchdog flag.
- `layer_idx` out 3: index of the current layer.
- `frame_cnt` out 8: index of the current frame.
- `ctrl_valid` out 1: request to the downstream controller.
- `ctrl_ready` in 1: downstream accepts the request.
- `ctrl_finish` in 1: downstream layer complete, one-cycle pulse.
- `w_num_o`, `h_num_o`, `c_num_o` out 8 each: layer dimensions.
- `kernel_mode_o`, `bit_mode_o` out 1 each: layer modes.
- `is_diff_o`, `is_first_o` out 1 each: frame and layer flags.

## Operation
- Config table:
  - `MAX_LAYERS` entries of 26 bits each; contents are not reset.
  - A write takes effect at the clock edge where `cfg_we` is sampled.
  - `cfg_we` is ignored while `busy`=1.
- Payload outputs are combinational from the table entry at `layer_idx`:
  - `is_first_o` = (`layer_idx`==0).
  - `is_diff_o` = (`frame_cnt`!=0).
  - The payload is stable for as long as `ctrl_valid` is high.
- **IDLE**:
  - `start`=1 and `abort`=0, with `num_layers_i`≠0 and `num_frames_i`≠0: latch both counts, set `layer_idx`=0, `frame_cnt`=0, clear `err`, go to ISSUE.
  - `start`=1 with either count equal to zero: go to DONE with no downstream request.
  - `start` and `abort` asserted together: `abort` wins and `start` is ignored.
- **ISSUE**: `ctrl_valid`=1.
  - On `ctrl_valid`&&`ctrl_ready`: go to WAIT and clear the watchdog.
  - `ctrl_finish` is ignored in this state.
- **WAIT**: `ctrl_valid`=0; the watchdog increments every cycle.
  - On `ctrl_finish`:
    - If `layer_idx` < layers−1: increment `layer_idx`, go to ISSUE.
    - Else if `frame_cnt` < frames−1: set `layer_idx`=0, increment `frame_cnt`, go to ISSUE.
    - Else: go to DONE.
  - If the watchdog reaches `TIMEOUT`−1 without a finish: set `err`=1 and go to IDLE with no `done` pulse.
  - `ctrl_finish` takes priority over the timeout when both occur in the same cycle.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
  - `layer_idx` and `frame_cnt` hold their final values until the next `start`.
- `abort` in ISSUE, WAIT or DONE:
  - Go to IDLE on the next edge with no `done` pulse; `err` is unchanged.
  - The downstream controller is not reset. If the handshake completes in the same cycle as `abort`, `abort` still wins.
- `start` while `busy`=1 is ignored.
- Width rules:
  - Counter comparisons are unsigned.
  - `num_layers_i` > `MAX_LAYERS` is clamped to `MAX_LAYERS`.
  - The watchdog counter is $clog2(TIMEOUT) bits wide and saturates.

## Timing
- Values after reset:
  - State = IDLE.
  - `busy`, `done`, `err`, `ctrl_valid` = 0.
  - `layer_idx`, `frame_cnt` = 0.
  - Payload outputs follow entry 0; `is_first_o`=1, `is_diff_o`=0.
- `start` sampled at edge N → `ctrl_valid`=1 and `busy`=1 from edge N+1.
- Handshake at edge M → `ctrl_valid`=0 from edge M+1.
- `ctrl_finish` sampled at edge F → next `ctrl_valid`=1 from F+1, or `done`=1 during F+1..F+2.
- Downstream ready turnaround is absorbed in ISSUE; `ctrl_valid` is held high until `ctrl_ready` is seen.
- State, counters, `done` and `ctrl_valid` are all registered; payload outputs are combinational from registers.

## Test plan
- **Basic run**: 3 layers × 2 frames, downstream ready after 2 cycles and finish after 10 → exactly 6 handshakes; payloads in order L0,L1,L2,L0,L1,L2; `is_first_o` high on handshakes 1 and 4; `is_diff_o` high on handshakes 4–6; a single `done` one cycle after the 6th finish.
- **Zero counts**: `start` with `num_frames_i`=0 → no `ctrl_valid`, `done` pulses at N+1..N+2, `busy` high for one cycle.
- **Watchdog**: `TIMEOUT`=16 and no finish → `err`=1 and IDLE 15 cycles after the handshake, no `done`; a later `start` clears `err`.
- **Abort**: `abort` asserted in WAIT at layer 1 → IDLE next cycle, no `done`, further finishes ignored; `abort` together with `start` in IDLE → stays IDLE.
- **Config writes**: `cfg_we` to entry 0 while busy → the table is unchanged and the next frame's L0 payload uses the old value; a write in IDLE is reflected on `w_num_o` the next cycle.
- **Reset mid-run**: `rst` asserted in ISSUE → `ctrl_valid`, `busy` and counters go to 0 immediately, asynchronously.
